// File: rtl/trace_player.sv
// Run-time programmable LANES x DEPTH stimulus trace.
// Playback runs one step per clock, with start/stop/loop control and registered outputs.
module trace_player #(
  parameter  int DEPTH = 32,
  parameter  int LANES = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LANES-1:0] wr_data,
  input  logic [AW-1:0]    cfg_last,
  input  logic             cfg_loop,
  input  logic             start,
  input  logic             stop,
  output logic [LANES-1:0] lanes,
  output logic [AW-1:0]    step,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;

  state_t           state_q, state_d;
  logic [LANES-1:0] mem_q [DEPTH];
  logic [LANES-1:0] lanes_q, lanes_d;
  logic [AW-1:0]    step_q, step_d;
  logic             done_q, done_d;
  logic [AW-1:0]    last_q, last_d;
  logic             loop_q, loop_d;
  logic [AW-1:0]    nextStep;

  assign nextStep = step_q + AW'(1);

  // The memory is cleared by reset, so a trace never survives a reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      lanes_q <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      last_q  <= '0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lanes_q <= lanes_d;
      step_q  <= step_d;
      done_q  <= done_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
    end
  end

  // Lanes are read from the memory's pre-edge contents, so a same-edge write shows up on the next pass.
  always_comb begin
    state_d = state_q;
    lanes_d = lanes_q;
    step_d  = step_q;
    done_d  = 1'b0;
    last_d  = last_q;
    loop_d  = loop_q;
    if (stop) begin
      state_d = IDLE;
      lanes_d = '0;
      step_d  = '0;
    end else if (start) begin
      state_d = PLAY;
      step_d  = '0;
      lanes_d = mem_q[0];
      last_d  = cfg_last;
      loop_d  = cfg_loop;
    end else begin
      case (state_q)
        PLAY: begin
          if (step_q != last_q) begin
            step_d  = nextStep;
            lanes_d = mem_q[nextStep];
          end else if (loop_q) begin
            step_d  = '0;
            lanes_d = mem_q[0];
          end else begin
            state_d = HOLD;
            done_d  = 1'b1;
          end
        end
        HOLD: begin
          state_d = HOLD;
        end
        default: begin
          state_d = IDLE;
          lanes_d = '0;
          step_d  = '0;
        end
      endcase
    end
  end

  assign lanes = lanes_q;
  assign step  = step_q;
  assign busy  = (state_q == PLAY);
  assign done  = done_q;

endmodule

// File: tb/tb_trace_player.sv
// Randomised bench for trace_player.
// A cycle-count reference model is checked every cycle, alongside hand-computed checkpoints.
module tb_trace_player;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [4:0] cfg_last = '0;
  logic       cfg_loop = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] lanes;
  logic [4:0] step;
  logic       busy;
  logic       done;

  int passed = 0;
  int total  = 0;

  trace_player #(.DEPTH(32), .LANES(4)) dut (
    .clock(clock), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .cfg_last(cfg_last), .cfg_loop(cfg_loop),
    .start(start), .stop(stop), .lanes(lanes), .step(step),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Reference model: the position is the number of edges elapsed since start.
  logic [3:0] mMem [32];
  bit         mActive = 1'b0;
  int         mN = 0;
  int         mLast = 0;
  bit         mLoop = 1'b0;
  logic [3:0] expLanes = '0;
  logic [4:0] expStep = '0;
  logic       expBusy = 1'b0;
  logic       expDone = 1'b0;

  initial for (int i = 0; i < 32; i++) mMem[i] = '0;

  always @(negedge resetn) begin
    for (int i = 0; i < 32; i++) mMem[i] = '0;
    mActive = 1'b0; mN = 0; mLast = 0; mLoop = 1'b0;
    expLanes = '0; expStep = '0; expBusy = 1'b0; expDone = 1'b0;
  end

  always @(posedge clock) begin
    if (resetn) begin
      expDone = 1'b0;
      if (stop) begin
        mActive = 1'b0;
      end else if (start) begin
        mActive = 1'b1; mN = 0; mLast = int'(cfg_last); mLoop = cfg_loop;
      end else if (mActive) begin
        mN = mN + 1;
        if (mLoop) mN = mN % (mLast + 1);
        else if (mN > mLast + 1) mN = mLast + 2;
      end
      if (!mActive) begin
        expLanes = '0; expStep = '0; expBusy = 1'b0;
      end else if (mLoop || mN <= mLast) begin
        expStep = 5'(mN); expLanes = mMem[mN]; expBusy = 1'b1;
      end else begin
        expBusy = 1'b0;
        expDone = (mN == mLast + 1);
      end
      if (wr_en) mMem[wr_addr] = wr_data;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    else passed++;
  endtask

  always @(negedge clock) begin
    checkOutput("lanes", 32'(lanes), 32'(expLanes));
    checkOutput("step", 32'(step), 32'(expStep));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("done", 32'(done), 32'(expDone));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic writeStep(input int addr, input logic [3:0] data);
    wr_en = 1'b1; wr_addr = 5'(addr); wr_data = data;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic pulseStart(input int last, input bit loopEn);
    cfg_last = 5'(last); cfg_loop = loopEn; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic applyStimulus();
    int pat[4] = '{1, 2, 4, 8};
    #1 resetn = 1'b0;
    #20 resetn = 1'b1;
    tick(1);

    writeStep(1, 4'b0001); writeStep(12, 4'b0001);
    writeStep(2, 4'b0010); writeStep(13, 4'b0010);
    pulseStart(31, 1'b0);
    checkOutput("t1 k+1 lanes", 32'(lanes), 32'h0);
    checkOutput("t1 k+1 busy", 32'(busy), 32'h1);
    tick(1); checkOutput("t1 k+2 lanes", 32'(lanes), 32'h1);
    tick(1); checkOutput("t1 k+3 lanes", 32'(lanes), 32'h2);
    tick(10); checkOutput("t1 k+13 lanes", 32'(lanes), 32'h1);
    tick(19); checkOutput("t1 k+32 step", 32'(step), 32'd31);
    checkOutput("t1 k+32 done", 32'(done), 32'h0);
    tick(1); checkOutput("t1 k+33 done", 32'(done), 32'h1);
    checkOutput("t1 k+33 busy", 32'(busy), 32'h0);
    tick(1); checkOutput("t1 k+34 done", 32'(done), 32'h0);
    checkOutput("t1 k+34 step", 32'(step), 32'd31);

    writeStep(0, 4'd1); writeStep(1, 4'd2); writeStep(2, 4'd4); writeStep(3, 4'd8);
    pulseStart(3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t2 loop lanes", 32'(lanes), 32'(pat[i % 4]));
      checkOutput("t2 loop busy", 32'(busy), 32'h1);
      tick(1);
    end

    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    checkOutput("t3 stop lanes", 32'(lanes), 32'h0);
    checkOutput("t3 stop busy", 32'(busy), 32'h0);

    pulseStart(10, 1'b0);
    tick(2); cfg_last = 5'd2;
    tick(3); checkOutput("t4 step5", 32'(step), 32'd5);
    pulseStart(2, 1'b0);
    checkOutput("t4 restart step", 32'(step), 32'd0);
    checkOutput("t4 restart lanes", 32'(lanes), 32'd1);

    writeStep(6, 4'b0110);
    pulseStart(7, 1'b1);
    tick(5);
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 4'b1111;
    tick(1);
    wr_en = 1'b0;
    checkOutput("t5 old mem6", 32'(lanes), 32'h6);
    tick(8); checkOutput("t5 new mem6", 32'(lanes), 32'hF);

    resetn = 1'b0;
    #1;
    checkOutput("t6 async lanes", 32'(lanes), 32'h0);
    checkOutput("t6 async busy", 32'(busy), 32'h0);
    #3 resetn = 1'b1;
    tick(1);
    pulseStart(3, 1'b0);
    tick(2); checkOutput("t6 zero lanes", 32'(lanes), 32'h0);
    checkOutput("t6 step2", 32'(step), 32'd2);

    for (int i = 0; i < 600; i++) begin
      wr_en    = ($urandom_range(0, 2) == 0);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = 4'($urandom);
      cfg_last = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      cfg_loop = 1'($urandom);
      start    = ($urandom_range(0, 15) == 0);
      stop     = ($urandom_range(0, 31) == 0);
      tick(1);
    end
    start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    tick(2);
  endtask

  initial begin
    applyStimulus();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/trace_player.md
Name: trace_player

Overview:
- Programmable stimulus sequencer for formal and simulation testbenches.
- Stores a LANES-wide, DEPTH-step trace that is written at run time through a simple write port.
- Plays the trace back one step per clock onto registered lane outputs, with start, stop and loop control.
- Replaces fixed per-testcase trace parameters, so one harness can drive several property checks (e.g. A/B/C/D handshake sequences) from a controller.

Parameters:
- DEPTH, 32, number of trace steps. Must be a power of two, ≥2.
- LANES, 4, number of output signals per step.
- AW, $clog2(DEPTH), step address width. Derived; not to be overridden.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- wr_en  input  1  trace memory write strobe.
- wr_addr  input  AW  step index to write.
- wr_data  input  LANES  lane values for that step.
- cfg_last  input  AW  index of the final step to play. Sampled on start.
- cfg_loop  input  1  1 = wrap to step 0 after cfg_last. Sampled on start.
- start  input  1  begin playback from step 0.
- stop  input  1  abort playback.
- lanes  output  LANES  current step's lane values (registered).
- step  output  AW  index of the step currently on lanes.
- busy  output  1  high while in PLAY.
- done  output  1  one-cycle pulse on the first cycle in HOLD.

Behaviour:
- Reset (resetn low, asynchronous):
  - All memory entries = 0.
  - lanes = 0, step = 0, busy = 0, done = 0.
  - State = IDLE; latched last = 0; latched loop = 0.
- Memory write:
  - When wr_en is high, mem[wr_addr] <= wr_data at the clock edge.
  - Writes are allowed in any state.
  - A read of the same address at the same edge returns the old content. There is no forwarding.
- States: IDLE, PLAY, HOLD. busy = (state == PLAY).
- Priority at each edge: stop > start > normal progression.
- stop (any state):
  - Next state = IDLE, lanes <= 0, step <= 0, done <= 0.
- start (no stop):
  - Next state = PLAY, step <= 0, lanes <= mem[0].
  - Latches last <= cfg_last and loop <= cfg_loop.
  - Applies from IDLE, PLAY (restart) or HOLD (replay).
- Start latency: start sampled at edge k puts step 0 on lanes during cycle k+1 and sets busy=1 from k+1.
- PLAY with step != last:
  - step <= step+1, lanes <= mem[step+1].
- PLAY with step == last and loop = 1:
  - step <= 0, lanes <= mem[0]. No done pulse. State stays PLAY indefinitely.
- PLAY with step == last and loop = 0:
  - Next state = HOLD; lanes and step hold; done <= 1.
- HOLD:
  - lanes and step hold the last step's values (saturating playback).
  - done is high only in the first HOLD cycle, then 0.
- IDLE: lanes = 0, step = 0.
- last = 0:
  - Without loop: step 0 is shown for one PLAY cycle, then HOLD.
  - With loop: mem[0] is re-read every cycle.
- Changes to cfg_last or cfg_loop after start have no effect until the next start.
- The step counter is AW bits wide. Wrap only occurs via loop; last ≤ DEPTH-1 by construction.
- Reset mid-PLAY: immediate return to the reset values above. Memory contents are lost (cleared).

Test Plan:
- Reset, then write lane 0 = 1 at steps 1 and 12, lane 1 = 1 at steps 2 and 13; cfg_last=31, cfg_loop=0; pulse start at edge k -> lanes=0 at k+1, lanes=4'b0001 at k+2, lanes=4'b0010 at k+3, lanes=4'b0001 at k+13. step=31 at k+32, done=1 at k+33 only, lanes/step frozen thereafter, busy=0 from k+33.
- cfg_last=3, cfg_loop=1, mem[0..3] = 1, 2, 4, 8 -> lanes cycles 1, 2, 4, 8, 1, 2, … continuously; done never asserts; busy stays 1.
- While playing with last=3 and loop=1, assert start and stop in the same cycle -> next cycle IDLE, lanes=0, step=0, busy=0.
- Mid-play restart: start again when step=5 -> next cycle step=0, lanes=mem[0]; cfg_last changed mid-play to 2 has no effect before restart.
- Write mem[6] = 4'b1111 at the same edge that loads step 6 -> lanes shows the old mem[6] value; the next pass shows 4'b1111.
- Deassert resetn asynchronously mid-PLAY (between edges) -> lanes, step, busy and done go to 0 immediately; subsequent start plays all-zero lanes.
